out_port_sink: RTL and testbench

//  Consumer end of the processor's output port. Captures each word the processor strobes out (out_en high)

---
 rtl/out_port_sink_pkg.sv | 31 +++
 rtl/out_port_fifo.sv | 55 +++++
 rtl/out_port_sink.sv | 118 +++++++++++
 tb/tb_out_port_sink.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/out_port_sink_pkg.sv
`default_nettype none
// ============================================================================
// Module   : out_port_sink_pkg
// Brief    : Shared defines and types for the processor out-port sink
//            (optional feature macro: OUTPORT_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
`ifndef inPortWidth
`define inPortWidth 16
`endif
`ifndef OUTPORT_DEPTH
`define OUTPORT_DEPTH 4
`endif
`ifndef OUTPORT_THRESH
`define OUTPORT_THRESH 3
`endif

package out_port_sink_pkg;

    typedef struct packed {
        logic full;
        logic empty;
    } fifoFlags_t;

    // Pointer width: index bits plus one wrap bit.
    function automatic int ptrWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/out_port_fifo.sv
`default_nettype none
// ============================================================================
// Module   : out_port_fifo
// Brief    : Wrap-bit FIFO: storage array, pointers, full/empty and level.
// Revision : 1.0 - initial release
// ============================================================================
module out_port_fifo
    import out_port_sink_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_wrEn,
    input  logic [DATA_W-1:0]          i_wrData,
    input  logic                       i_rdEn,
    output logic [DATA_W-1:0]          o_rdData,
    output fifoFlags_t                 o_flags,
    output logic [ptrWidth(DEPTH)-1:0] o_level
);

    localparam int c_PW = ptrWidth(DEPTH);
    localparam int c_IW = c_PW - 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_PW-1:0]   r_wrPtr;
    logic [c_PW-1:0]   r_rdPtr;
    logic [c_IW-1:0]   w_wrIdx;
    logic [c_IW-1:0]   w_rdIdx;

    assign w_wrIdx = r_wrPtr[c_IW-1:0];
    assign w_rdIdx = r_rdPtr[c_IW-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (i_wrEn) r_wrPtr <= r_wrPtr + c_PW'(1);
            if (i_rdEn) r_rdPtr <= r_rdPtr + c_PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_wrEn) r_mem[w_wrIdx] <= i_wrData;
    end

    assign o_flags.empty = (r_wrPtr == r_rdPtr);
    assign o_flags.full  = (w_wrIdx == w_rdIdx) && (r_wrPtr[c_PW-1] != r_rdPtr[c_PW-1]);
    assign o_level       = r_wrPtr - r_rdPtr;
    assign o_rdData      = o_flags.empty ? '0 : r_mem[w_rdIdx];

endmodule
`default_nettype wire

// File: rtl/out_port_sink.sv
`default_nettype none
// ============================================================================
// Module   : out_port_sink
// Brief    : Processor out-port consumer: FIFO buffering, valid/ready device
//            handshake, sticky overflow; irq_req FSM when OUTPORT_IRQ_EN set.
// Revision : 1.0 - initial release
// ============================================================================
module out_port_sink
    import out_port_sink_pkg::*;
#(
    parameter int DATA_W = `inPortWidth,
    parameter int DEPTH  = `OUTPORT_DEPTH,
    parameter int THRESH = `OUTPORT_THRESH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          out_data,
    input  logic                       out_en,
    output logic [DATA_W-1:0]          dev_data,
    output logic                       dev_valid,
    input  logic                       dev_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    input  logic                       clear_ovf,
    output logic                       irq_req
);

    localparam int c_PW = ptrWidth(DEPTH);

    fifoFlags_t w_flags;
    logic       w_pop;
    logic       w_push;
    logic       w_drop;
    logic       r_overflow;

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (THRESH < 1) || (THRESH > DEPTH))
    begin : g_paramCheck
        $error("out_port_sink: DEPTH must be a power of two >= 2 and THRESH in 1..DEPTH");
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
    assign w_pop  = dev_valid && dev_ready;
    assign w_push = out_en && (!w_flags.full || w_pop);
    assign w_drop = out_en && w_flags.full && !w_pop;

    out_port_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .i_wrEn   (w_push),
        .i_wrData (out_data),
        .i_rdEn   (w_pop),
        .o_rdData (dev_data),
        .o_flags  (w_flags),
        .o_level  (fifo_level)
    );

    assign dev_valid = !w_flags.empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;

`ifdef OUTPORT_IRQ_EN
    localparam logic [0:0]      c_ST_IDLE      = 1'b0;
    localparam logic [0:0]      c_ST_ARMED_OFF = 1'b1;
    localparam logic [c_PW-1:0] c_THRESH_LVL   = c_PW'(THRESH);

    logic [0:0] r_state;
    logic [0:0] w_stateNext;
    logic       r_irq;
    logic       w_irqNext;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_irq   <= w_irqNext;
        end
    end

    // Pulse once on the upward threshold crossing; re-arm only after dropping below.
    always_comb begin
        w_stateNext = r_state;
        w_irqNext   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (fifo_level >= c_THRESH_LVL) begin
                    w_stateNext = c_ST_ARMED_OFF;
                    w_irqNext   = 1'b1;
                end
            end
            c_ST_ARMED_OFF: begin
                if (fifo_level < c_THRESH_LVL) w_stateNext = c_ST_IDLE;
            end
            default: w_stateNext = c_ST_IDLE;
        endcase
    end

    assign irq_req = r_irq;
`else
    assign irq_req = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_out_port_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_port_sink
// Brief    : Scoreboard bench for out_port_sink (irq checks follow OUTPORT_IRQ_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_port_sink;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int THRESH = 3;
    localparam int LW     = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] out_data = '0;
    logic              out_en = 1'b0;
    logic              dev_ready = 1'b0;
    logic              clear_ovf = 1'b0;
    logic [DATA_W-1:0] dev_data;
    logic              dev_valid;
    logic [LW-1:0]     fifo_level;
    logic              overflow;
    logic              irq_req;

    int nChecks = 0;
    int nPass   = 0;

    logic [DATA_W-1:0] sbQ[$];
    logic [DATA_W-1:0] popLog[$];
    logic              mOvf = 1'b0;
    int                irqHigh = 0;
    int                irqRise = 0;
    logic              irqPrev = 1'b0;

    always #5 clk = ~clk;

    out_port_sink #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .THRESH (THRESH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .out_data   (out_data),
        .out_en     (out_en),
        .dev_data   (dev_data),
        .dev_valid  (dev_valid),
        .dev_ready  (dev_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .clear_ovf  (clear_ovf),
        .irq_req    (irq_req)
    );

    // Model evaluated mid-cycle: predicts the coming edge from the driven inputs.
    always @(negedge clk) begin : scoreboard
        logic [DATA_W-1:0] expWord;
        logic              dropped;
        if (reset) begin
            sbQ.delete();
            mOvf    = 1'b0;
            irqPrev = 1'b0;
        end else begin
            nChecks++;
            if (dev_valid !== (sbQ.size() != 0))
                $display("FAIL sb_valid: dev_valid=%b required %b", dev_valid, sbQ.size() != 0);
            else nPass++;
            nChecks++;
            if (fifo_level !== LW'(sbQ.size()))
                $display("FAIL sb_level: fifo_level=%0d required %0d", fifo_level, sbQ.size());
            else nPass++;
            nChecks++;
            if (overflow !== mOvf)
                $display("FAIL sb_overflow: overflow=%b required %b", overflow, mOvf);
            else nPass++;
            if (irq_req === 1'b1) irqHigh++;
            if (irq_req === 1'b1 && !irqPrev) irqRise++;
            irqPrev = irq_req;
            dropped = 1'b0;
            if (dev_ready && sbQ.size() != 0) begin
                expWord = sbQ.pop_front();
                nChecks++;
                if (dev_data !== expWord)
                    $display("FAIL sb_data: dev_data=%h required %h", dev_data, expWord);
                else nPass++;
                popLog.push_back(dev_data);
            end
            if (out_en) begin
                if (sbQ.size() < DEPTH) sbQ.push_back(out_data);
                else dropped = 1'b1;
            end
            if (dropped) mOvf = 1'b1;
            else if (clear_ovf) mOvf = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] w);
        out_en   = 1'b1;
        out_data = w;
        tick();
        out_en   = 1'b0;
    endtask

    task automatic drain();
        dev_ready = 1'b1;
        for (int i = 0; i < 12 && fifo_level != 0; i++) tick();
        dev_ready = 1'b0;
        nChecks++;
        if (fifo_level !== '0) $display("FAIL drain_timeout: fifo_level=%0d required 0", fifo_level);
        else nPass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        nChecks++; if (dev_valid !== 1'b0) $display("FAIL rst_valid: got %b required 0", dev_valid); else nPass++;
        nChecks++; if (dev_data !== '0) $display("FAIL rst_data: got %h required 0000", dev_data); else nPass++;
        nChecks++; if (fifo_level !== '0) $display("FAIL rst_level: got %0d required 0", fifo_level); else nPass++;
        nChecks++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b required 0", overflow); else nPass++;
        nChecks++; if (irq_req !== 1'b0) $display("FAIL rst_irq: got %b required 0", irq_req); else nPass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream();
        dev_ready = 1'b0;
        push(16'h0101);
        push(16'h0202);
        push(16'h0303);
        nChecks++; if (fifo_level !== 3'd3) $display("FAIL mid_level: got %0d required 3", fifo_level); else nPass++;
        #2 reset = 1'b1;
        #1;
        nChecks++; if (dev_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b required 0", dev_valid); else nPass++;
        nChecks++; if (fifo_level !== '0) $display("FAIL mid_rst_level: got %0d required 0", fifo_level); else nPass++;
        nChecks++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf: got %b required 0", overflow); else nPass++;
        tick();
        reset = 1'b0;
        push(16'h00AA);
        nChecks++; if (dev_valid !== 1'b1) $display("FAIL mid_aa_valid: got %b required 1", dev_valid); else nPass++;
        nChecks++; if (dev_data !== 16'h00AA) $display("FAIL mid_aa_data: got %h required 00aa", dev_data); else nPass++;
        drain();
    endtask

    task automatic test_overflow();
        logic [DATA_W-1:0] words [5] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        int seen5555;
        dev_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(words[i]);
        nChecks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d required 4", fifo_level); else nPass++;
        nChecks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b required 1", overflow); else nPass++;
        nChecks++; if (dev_data !== 16'h1111) $display("FAIL ovf_head: got %h required 1111", dev_data); else nPass++;
        popLog.delete();
        drain();
        nChecks++; if (popLog.size() != 4) $display("FAIL ovf_count: got %0d required 4", popLog.size()); else nPass++;
        seen5555 = 0;
        for (int i = 0; i < popLog.size(); i++) begin
            if (popLog[i] == 16'h5555) seen5555++;
            if (i < 4) begin
                nChecks++;
                if (popLog[i] !== words[i]) $display("FAIL ovf_order%0d: got %h required %h", i, popLog[i], words[i]);
                else nPass++;
            end
        end
        nChecks++; if (seen5555 != 0) $display("FAIL ovf_dropped_seen: got %0d required 0", seen5555); else nPass++;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        nChecks++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow); else nPass++;
    endtask

    task automatic test_full_push_pop();
        dev_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'h0A00 + 16'(i));
        popLog.delete();
        out_en    = 1'b1;
        out_data  = 16'h6666;
        dev_ready = 1'b1;
        tick();
        out_en    = 1'b0;
        dev_ready = 1'b0;
        nChecks++; if (fifo_level !== 3'd4) $display("FAIL fpp_level: got %0d required 4", fifo_level); else nPass++;
        nChecks++; if (overflow !== 1'b0) $display("FAIL fpp_ovf: got %b required 0", overflow); else nPass++;
        drain();
        nChecks++; if (popLog.size() != 5) $display("FAIL fpp_count: got %0d required 5", popLog.size()); else nPass++;
        if (popLog.size() != 0) begin
            nChecks++;
            if (popLog[popLog.size()-1] !== 16'h6666)
                $display("FAIL fpp_last: got %h required 6666", popLog[popLog.size()-1]);
            else nPass++;
        end
        nChecks++; if (overflow !== 1'b0) $display("FAIL fpp_ovf_end: got %b required 0", overflow); else nPass++;
    endtask

    task automatic test_back_to_back();
        int maxLevel = 0;
        dev_ready = 1'b1;
        for (int w = 1; w <= 10; w++) begin
            out_en   = 1'b1;
            out_data = 16'(w);
            tick();
            if (int'(fifo_level) > maxLevel) maxLevel = int'(fifo_level);
            nChecks++;
            if (dev_valid !== 1'b1 || dev_data !== 16'(w))
                $display("FAIL b2b_word%0d: valid=%b data=%h required 1/%h", w, dev_valid, dev_data, 16'(w));
            else nPass++;
        end
        out_en = 1'b0;
        tick();
        dev_ready = 1'b0;
        nChecks++; if (maxLevel > 1) $display("FAIL b2b_maxlevel: got %0d required <=1", maxLevel); else nPass++;
        nChecks++; if (fifo_level !== '0) $display("FAIL b2b_empty: got %0d required 0", fifo_level); else nPass++;
    endtask

    task automatic test_clear_priority();
        dev_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push(16'h0B00 + 16'(i));
        out_en    = 1'b1;
        out_data  = 16'h0BFF;
        clear_ovf = 1'b1;
        tick();
        out_en    = 1'b0;
        clear_ovf = 1'b0;
        nChecks++; if (overflow !== 1'b1) $display("FAIL clr_prio: got %b required 1", overflow); else nPass++;
        tick();
        nChecks++; if (overflow !== 1'b1) $display("FAIL clr_sticky: got %b required 1", overflow); else nPass++;
        clear_ovf = 1'b1;
        tick();
        clear_ovf = 1'b0;
        nChecks++; if (overflow !== 1'b0) $display("FAIL clr_alone: got %b required 0", overflow); else nPass++;
        drain();
    endtask

    task automatic test_irq();
`ifdef OUTPORT_IRQ_EN
        tick();
        irqHigh = 0;
        irqRise = 0;
        dev_ready = 1'b0;
        push(16'h0C01);
        push(16'h0C02);
        push(16'h0C03);
        tick();
        tick();
        nChecks++; if (irqRise != 1) $display("FAIL irq_first: pulses=%0d required 1", irqRise); else nPass++;
        nChecks++; if (irqHigh != 1) $display("FAIL irq_width: high cycles=%0d required 1", irqHigh); else nPass++;
        push(16'h0C04);
        tick();
        tick();
        nChecks++; if (irqRise != 1) $display("FAIL irq_norepeat: pulses=%0d required 1", irqRise); else nPass++;
        dev_ready = 1'b1;
        tick();
        tick();
        dev_ready = 1'b0;
        nChecks++; if (fifo_level !== 3'd2) $display("FAIL irq_lvl2: got %0d required 2", fifo_level); else nPass++;
        tick();
        push(16'h0C05);
        tick();
        tick();
        nChecks++; if (irqRise != 2) $display("FAIL irq_rearm: pulses=%0d required 2", irqRise); else nPass++;
        nChecks++; if (irqHigh != 2) $display("FAIL irq_rearm_width: high cycles=%0d required 2", irqHigh); else nPass++;
        drain();
`else
        nChecks++; if (irqHigh != 0) $display("FAIL irq_tied: high cycles=%0d required 0", irqHigh); else nPass++;
`endif
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_clear_priority();
        test_irq();
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
